chain_latency_probe: RTL and testbench

- Drives a step edge into a bank of parallel delay-chain lanes and samples the far end of each lane.
- Reports, per lane, the clock-cycle latency of the step plus timeout and glitch status.
- Sits on the opposite end of the delay chains from the input pins: it launches the edge and receives it, replacing manual pin toggling for chain characterisation.
- One probe serves all lanes at once, sharing a single latency counter.

---
 rtl/chain_latency_probe_pkg.sv | 18 +
 rtl/chain_latency_probe_if.sv | 16 +
 rtl/chain_latency_probe_capture.sv | 28 ++
 rtl/chain_latency_probe.sv | 102 ++++++++++
 tb/tb_chain_latency_probe.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/chain_latency_probe_pkg.sv
// chain_probe_pkg: shared state encoding, default sizing and lat field helper for the chain probe
package chain_probe_pkg;
    localparam int DEF_LANES = 8;
    localparam int DEF_CNT_W = 12;
    localparam int DEF_TIMEOUT = 1023;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        LAUNCH  = 3'd2,
        MEASURE = 3'd3,
        DONE    = 3'd4
    } state_e;

    function automatic logic [DEF_CNT_W-1:0] lat_field(input logic [DEF_LANES*DEF_CNT_W-1:0] lat, input int idx);
        return lat[idx*DEF_CNT_W +: DEF_CNT_W];
    endfunction
endpackage

// File: rtl/chain_latency_probe_if.sv
// chain_latency_probe_if: start/status/result bundle between a requester and the chain probe
interface chain_latency_probe_if #(
    parameter int LANES = 8,
    parameter int CNT_W = 12
);
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [LANES*CNT_W-1:0] lat;
    logic [LANES-1:0]       lane_ok;
    logic [LANES-1:0]       lane_glitch;
    logic                   flush_err;

    modport master(output start, input busy, done, lat, lane_ok, lane_glitch, flush_err);
    modport slave(input start, output busy, done, lat, lane_ok, lane_glitch, flush_err);
endinterface

// File: rtl/chain_latency_probe_capture.sv
// chain_lane_capture: per-lane arrival latency, arrival flag and sticky glitch flag
module chain_lane_capture #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             measuring,
    input  logic             sample,
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] lat,
    output logic             ok,
    output logic             glitch
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lat    <= '0;
            ok     <= 1'b0;
            glitch <= 1'b0;
        end else if (measuring) begin
            if (!ok && sample) begin
                lat <= cnt;
                ok  <= 1'b1;
            end
            if (ok && !sample) glitch <= 1'b1;
        end
    end
endmodule

// File: rtl/chain_latency_probe.sv
// chain_latency_probe: launches a step into all delay-chain lanes and times its arrival per lane
module chain_latency_probe
    import chain_probe_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    chain_latency_probe_if.slave  bus,
    output logic [LANES-1:0]      chain_in,
    input  logic [LANES-1:0]      chain_out
);
    state_e                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   drive;
    logic                   zero_prev;
    logic                   flush_err;
    logic [LANES*CNT_W-1:0] lat_w;
    logic [LANES-1:0]       ok_w;
    logic [LANES-1:0]       glitch_w;
    logic                   at_limit;
    logic                   all_zero;
    logic                   all_ok;
    logic                   clear;
    logic                   measuring;

    always_comb begin
        at_limit  = cnt == CNT_W'(TIMEOUT);
        all_zero  = chain_out == '0;
        // a lane arriving this cycle counts, so the last arrival and timeout can coincide
        all_ok    = &(ok_w | chain_out);
        clear     = state == IDLE && bus.start;
        measuring = state == MEASURE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            drive     <= 1'b0;
            zero_prev <= 1'b0;
            flush_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state     <= FLUSH;
                    cnt       <= '0;
                    zero_prev <= 1'b0;
                    flush_err <= 1'b0;
                end
                FLUSH: begin
                    zero_prev <= all_zero;
                    if (all_zero && zero_prev) begin
                        state <= LAUNCH;
                        cnt   <= '0;
                    end else if (at_limit) begin
                        state     <= DONE;
                        flush_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LAUNCH: begin
                    state <= MEASURE;
                    drive <= 1'b1;
                    cnt   <= '0;
                end
                MEASURE: if (all_ok || at_limit) begin
                    state <= DONE;
                    drive <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        chain_lane_capture #(.CNT_W(CNT_W)) u_cap (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .measuring (measuring),
            .sample    (chain_out[g]),
            .cnt       (cnt),
            .lat       (lat_w[g*CNT_W +: CNT_W]),
            .ok        (ok_w[g]),
            .glitch    (glitch_w[g])
        );
    end

    assign chain_in        = {LANES{drive}};
    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.lat         = lat_w;
    assign bus.lane_ok     = ok_w;
    assign bus.lane_glitch = glitch_w;
    assign bus.flush_err   = flush_err;
endmodule

// File: tb/tb_chain_latency_probe.sv
// tb_chain_latency_probe: drives modelled delay-chain lanes and checks probe results against a reference model
module tb_chain_latency_probe;
    import chain_probe_pkg::*;

    localparam int TO = 100;
    localparam int NL = 8;
    localparam int CW = 12;
    localparam int NONE = -99;

    logic            clk;
    logic            rst;
    logic [NL-1:0]   chain_in;
    logic [NL-1:0]   chain_out;
    logic [NL-1:0]   force0;
    logic [255:0]    hist;
    int              dly [NL];
    int              total;
    int              bad;

    chain_latency_probe_if #(.LANES(NL), .CNT_W(CW)) bus ();

    chain_latency_probe #(.LANES(NL), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .chain_in  (chain_in),
        .chain_out (chain_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lane model: delay d >= 0 is a d-flop chain, -1 stuck low, -2 stuck high
    always @(posedge clk) hist <= {hist[254:0], chain_in[0]};

    always_comb begin
        chain_out = '0;
        for (int i = 0; i < NL; i++)
            chain_out[i] = (dly[i] == -2 ? 1'b1 : dly[i] == -1 ? 1'b0 :
                            dly[i] == 0 ? chain_in[0] : hist[dly[i]-1]) & ~force0[i];
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model(input int g_lane, input int g_at, output logic [NL-1:0] e_ok, output logic [NL-1:0] e_gl,
                         output logic [NL*CW-1:0] e_lat, output logic e_ferr, output int e_done, output int e_launch);
        int mend;
        e_ok = '0; e_gl = '0; e_lat = '0; e_ferr = 1'b0; mend = 0;
        e_launch = 3;
        for (int i = 0; i < NL; i++) if (dly[i] == -2) e_ferr = 1'b1;
        if (e_ferr) begin
            e_done = TO + 1;
            e_launch = -1;
            return;
        end
        for (int i = 0; i < NL; i++)
            if (dly[i] >= 0 && dly[i] <= TO) begin
                e_ok[i] = 1'b1;
                e_lat[i*CW +: CW] = CW'(dly[i]);
                if (dly[i] > mend) mend = dly[i];
            end
        if (e_ok != '1) mend = TO;
        if (g_lane >= 0 && e_ok[g_lane] && g_at > dly[g_lane] && g_at <= mend) e_gl[g_lane] = 1'b1;
        e_done = e_launch + mend + 1;
    endtask

    // one probe run; cycle 0 is the first cycle after the start edge
    task automatic run(input int g_lane, input int g_at, input int rst_at, input int bstart_at,
                       output int done_cyc, output int ndone, output int launch_cyc);
        int m;
        done_cyc = -1; ndone = 0; launch_cyc = -1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (chain_in[0] && launch_cyc < 0) launch_cyc = cyc;
            m = launch_cyc < 0 ? -1 : cyc - launch_cyc;
            if (bus.done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            force0 = (g_lane >= 0 && m == g_at) ? NL'(1 << g_lane) : '0;
            bus.start = m == bstart_at;
            rst = m == rst_at;
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0;
                break;
            end
        end
        force0 = '0;
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b0; force0 = '0;
        for (int i = 0; i < NL; i++) dly[i] = 0;
        idle(3);
        rst = 1'b0;
        idle(1);
        total += 7;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (chain_in !== '0) begin bad++; $display("FAIL reset_chain_in got %h want 0", chain_in); end
        if (bus.lat !== '0) begin bad++; $display("FAIL reset_lat got %h want 0", bus.lat); end
        if (bus.lane_ok !== '0) begin bad++; $display("FAIL reset_ok got %h want 0", bus.lane_ok); end
        if (bus.lane_glitch !== '0) begin bad++; $display("FAIL reset_glitch got %h want 0", bus.lane_glitch); end
        if (bus.flush_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got %b want 0", bus.flush_err); end
    endtask

    task automatic test_scenario(input string name, input int g_lane, input int g_at, input int bstart_at);
        logic [NL-1:0] e_ok, e_gl;
        logic [NL*CW-1:0] e_lat;
        logic e_ferr;
        int e_done, e_launch, done_cyc, ndone, launch_cyc;
        idle(160);
        model(g_lane, g_at, e_ok, e_gl, e_lat, e_ferr, e_done, e_launch);
        run(g_lane, g_at, NONE, bstart_at, done_cyc, ndone, launch_cyc);
        total += 7 + NL;
        if (bus.lane_ok !== e_ok) begin bad++; $display("FAIL %s lane_ok got %h want %h", name, bus.lane_ok, e_ok); end
        if (bus.lane_glitch !== e_gl) begin bad++; $display("FAIL %s lane_glitch got %h want %h", name, bus.lane_glitch, e_gl); end
        if (bus.flush_err !== e_ferr) begin bad++; $display("FAIL %s flush_err got %b want %b", name, bus.flush_err, e_ferr); end
        if (done_cyc != e_done) begin bad++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, e_done); end
        if (launch_cyc != e_launch) begin bad++; $display("FAIL %s launch_cycle got %0d want %0d", name, launch_cyc, e_launch); end
        if (ndone != 1) begin bad++; $display("FAIL %s done_pulses got %0d want 1", name, ndone); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s busy_after got %b want 0", name, bus.busy); end
        for (int i = 0; i < NL; i++)
            if (lat_field(bus.lat, i) !== lat_field(e_lat, i)) begin
                bad++;
                $display("FAIL %s lat[%0d] got %0d want %0d", name, i, lat_field(bus.lat, i), lat_field(e_lat, i));
            end
    endtask

    task automatic test_loopback;
        for (int i = 0; i < NL; i++) dly[i] = 0;
        test_scenario("loopback", -1, NONE, NONE);
    endtask

    task automatic test_flop_chains_and_hold;
        logic [NL*CW-1:0] held;
        for (int i = 0; i < NL; i++) dly[i] = 10 * i + 5;
        test_scenario("flop_chains", -1, NONE, 20);
        held = '0;
        for (int i = 0; i < NL; i++) held[i*CW +: CW] = CW'(10 * i + 5);
        idle(50);
        total += 2;
        if (bus.lat !== held) begin bad++; $display("FAIL hold_lat got %h want %h", bus.lat, held); end
        if (bus.lane_ok !== 8'hFF) begin bad++; $display("FAIL hold_ok got %h want ff", bus.lane_ok); end
    endtask

    task automatic test_dead_lane;
        for (int i = 0; i < NL; i++) dly[i] = 20;
        dly[3] = -1;
        test_scenario("dead_lane", -1, NONE, NONE);
    endtask

    task automatic test_stuck_high;
        for (int i = 0; i < NL; i++) dly[i] = 0;
        dly[5] = -2;
        test_scenario("stuck_high", -1, NONE, NONE);
    endtask

    task automatic test_glitch;
        for (int i = 0; i < NL; i++) dly[i] = 12;
        dly[0] = 4;
        dly[7] = 30;
        test_scenario("glitch", 0, 8, NONE);
    endtask

    task automatic test_timeout_edge;
        for (int i = 0; i < NL; i++) dly[i] = $urandom_range(0, 50);
        dly[0] = TO;
        dly[1] = TO + 1;
        test_scenario("timeout_edge", -1, NONE, NONE);
        for (int i = 0; i < NL; i++) dly[i] = $urandom_range(0, 50);
        dly[6] = TO;
        test_scenario("arrive_at_timeout", -1, NONE, NONE);
    endtask

    task automatic test_random;
        int gl;
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < NL; i++) dly[i] = $urandom_range(0, 60);
            if ($urandom_range(0, 3) == 0) dly[$urandom_range(0, NL-1)] = -1;
            gl = $urandom_range(0, NL-1);
            if (dly[gl] < 0) gl = -1;
            test_scenario("random", gl, gl < 0 ? NONE : dly[gl] + $urandom_range(1, 15), NONE);
        end
    endtask

    task automatic test_reset_mid;
        int done_cyc, ndone, launch_cyc;
        for (int i = 0; i < NL; i++) dly[i] = i < 4 ? 5 : 40;
        idle(160);
        run(-1, NONE, 10, 5, done_cyc, ndone, launch_cyc);
        total += 8;
        if (ndone != 0) begin bad++; $display("FAIL rst_mid done_pulses got %0d want 0", ndone); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_mid done got %b want 0", bus.done); end
        if (chain_in !== '0) begin bad++; $display("FAIL rst_mid chain_in got %h want 0", chain_in); end
        if (bus.lat !== '0) begin bad++; $display("FAIL rst_mid lat got %h want 0", bus.lat); end
        if (bus.lane_ok !== '0) begin bad++; $display("FAIL rst_mid ok got %h want 0", bus.lane_ok); end
        if (bus.lane_glitch !== '0) begin bad++; $display("FAIL rst_mid glitch got %h want 0", bus.lane_glitch); end
        if (bus.flush_err !== 1'b0) begin bad++; $display("FAIL rst_mid ferr got %b want 0", bus.flush_err); end
        idle(20);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy_later got %b want 0", bus.busy); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_loopback;
        test_flop_chains_and_hold;
        test_dead_lane;
        test_stuck_high;
        test_glitch;
        test_timeout_edge;
        test_random;
        test_reset_mid;
        test_loopback;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
